// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and boot-sequencer state encoding
package cpu_pkg;

  localparam int CPU_DATA_W   = 11;
  localparam int CPU_ADDR_W   = 3;
  localparam int CPU_OPCODE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CPU_RST = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } boot_state_t;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// rtl/cpu_boot_ctrl_if.sv - program-load stream between host and boot sequencer
interface cpu_boot_ctrl_if #(
  parameter int DATA_W = 11
);

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;

  modport master (output ld_valid, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);

endinterface

// File: rtl/boot_run_counter.sv
// rtl/boot_run_counter.sv - loadable down-counter with zero flag, shared by reset and run countdowns
module boot_run_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// rtl/cpu_boot_ctrl.sv - streams a program into CPU RAM, pulses CPU reset, then runs the PC for run_len cycles
module cpu_boot_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int CNT_W      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  cpu_boot_ctrl_if.slave    ld,
  input  logic [CNT_W-1:0]  run_len,
  input  logic              abort,
  input  logic              restart,
  output logic              cpu_reset,
  output logic              PC_Enable,
  output logic              RAM_Write_Enable,
  output logic [ADDR_W-1:0] RAM_Write_Address,
  output logic [DATA_W-1:0] RAM_Write_Data,
  output logic              done,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        state
);

  localparam int WL_W = ADDR_W + 1;

  boot_state_t       state_q;
  logic              ready_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;

  assign accept      = ld.ld_valid && ready_q;
  assign ld.ld_ready = ready_q;
  assign state       = state_q;

  // Counter holds RST_CYCLES-1 / run_len-1 so the zero flag marks the final cycle of each phase.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      S_LOAD: begin
        if (!ready_q) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(RST_CYCLES - 1);
        end
      end
      S_CPU_RST: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (run_len != '0) begin
          cnt_load = 1'b1;
          cnt_val  = run_len - CNT_W'(1);
        end
      end
      S_RUN:   cnt_dec = 1'b1;
      default: ;
    endcase
  end

  boot_run_counter #(.W(CNT_W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      ready_q           <= 1'b0;
      wr_ptr            <= '0;
      words_loaded      <= '0;
      cpu_reset         <= 1'b0;
      PC_Enable         <= 1'b0;
      RAM_Write_Enable  <= 1'b0;
      RAM_Write_Address <= '0;
      RAM_Write_Data    <= '0;
      done              <= 1'b0;
    end else begin
      RAM_Write_Enable <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            state_q           <= S_LOAD;
            RAM_Write_Enable  <= 1'b1;
            RAM_Write_Address <= '0;
            RAM_Write_Data    <= ld.ld_data;
            wr_ptr            <= ADDR_W'(1);
            words_loaded      <= WL_W'(1);
            if (ld.ld_last) ready_q <= 1'b0;
          end
        end
        S_LOAD: begin
          // ready low here means the final strobe is on the bus this cycle
          if (!ready_q) begin
            state_q   <= S_CPU_RST;
            cpu_reset <= 1'b1;
          end else if (accept) begin
            RAM_Write_Enable  <= 1'b1;
            RAM_Write_Address <= wr_ptr;
            RAM_Write_Data    <= ld.ld_data;
            wr_ptr            <= wr_ptr + ADDR_W'(1);
            words_loaded      <= words_loaded + WL_W'(1);
            if (ld.ld_last || (wr_ptr == '1)) ready_q <= 1'b0;
          end
        end
        S_CPU_RST: begin
          if (cnt_zero) begin
            cpu_reset <= 1'b0;
            if (run_len == '0) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              PC_Enable <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort || cnt_zero) begin
            state_q   <= S_DONE;
            PC_Enable <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DONE: begin
          if (restart) begin
            state_q <= S_IDLE;
            done    <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
